// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard tracking between issue and writeback.
// Optional macro HAZARD_FWD_EN enables forwarding from ready slots.
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 3,
  parameter int LAT_W   = 2,
  parameter int STALL_W = 16,
  localparam int SEL_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_chk_rs1,
  input  logic              issue_chk_rs2,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_we,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs1_sel,
  output logic [SEL_W-1:0]  fwd_rs2_sel,
  output logic [SEL_W-1:0]  inflight_cnt,
  output logic [STALL_W-1:0] stall_cycles
);

  logic [DEPTH-1:0]             r_v;
  logic [DEPTH-1:0][REG_AW-1:0] r_rd;
  logic [DEPTH-1:0][LAT_W-1:0]  r_rem;
  logic [SEL_W-1:0]             r_cnt;
  logic [STALL_W-1:0]           r_sc;

  logic                         w_hit1;
  logic                         w_hit2;
  logic                         w_st1;
  logic                         w_st2;
  logic [SEL_W-1:0]             w_sel1;
  logic [SEL_W-1:0]             w_sel2;
  logic                         w_stall;
  logic                         w_acc;
  logic [DEPTH-1:0]             w_nv;
  logic [DEPTH-1:0][REG_AW-1:0] w_nrd;
  logic [DEPTH-1:0][LAT_W-1:0]  w_nrem;
  logic [SEL_W-1:0]             w_ncnt;
`ifdef HAZARD_FWD_EN
  logic                         w_rdy1;
  logic                         w_rdy2;
  logic [SEL_W-1:0]             w_idx1;
  logic [SEL_W-1:0]             w_idx2;
`endif

  // Descending scan so the youngest (lowest) slot overrides older ones.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
`ifdef HAZARD_FWD_EN
    w_rdy1 = 1'b0;
    w_rdy2 = 1'b0;
    w_idx1 = '0;
    w_idx2 = '0;
`endif
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (issue_chk_rs1 && r_v[k] &&
          r_rd[k] == issue_rs1 && issue_rs1 != '0) begin
        w_hit1 = 1'b1;
`ifdef HAZARD_FWD_EN
        w_rdy1 = (r_rem[k] == '0);
        w_idx1 = SEL_W'(k+1);
`endif
      end
      if (issue_chk_rs2 && r_v[k] &&
          r_rd[k] == issue_rs2 && issue_rs2 != '0) begin
        w_hit2 = 1'b1;
`ifdef HAZARD_FWD_EN
        w_rdy2 = (r_rem[k] == '0);
        w_idx2 = SEL_W'(k+1);
`endif
      end
    end
  end

  always_comb begin
`ifdef HAZARD_FWD_EN
    w_st1  = w_hit1 & ~w_rdy1;
    w_st2  = w_hit2 & ~w_rdy2;
    w_sel1 = (w_hit1 && w_rdy1) ? w_idx1 : '0;
    w_sel2 = (w_hit2 && w_rdy2) ? w_idx2 : '0;
`else
    w_st1  = w_hit1;
    w_st2  = w_hit2;
    w_sel1 = '0;
    w_sel2 = '0;
`endif
  end

  assign w_stall = issue_valid & ~flush & (w_st1 | w_st2);
  assign w_acc   = issue_valid & ~w_stall & ~flush;

  always_comb begin
    w_nv   = '0;
    w_nrd  = '0;
    w_nrem = '0;
    w_ncnt = '0;
    for (int k = 1; k < DEPTH; k++) begin
      w_nv[k]   = r_v[k-1];
      w_nrd[k]  = r_rd[k-1];
      w_nrem[k] = (r_rem[k-1] == '0) ? '0 :
                  r_rem[k-1] - LAT_W'(1);
    end
    w_nv[0]   = w_acc & issue_we & (issue_rd != '0);
    w_nrd[0]  = issue_rd;
    w_nrem[0] = issue_lat;
    if (flush) w_nv = '0;
    for (int k = 0; k < DEPTH; k++)
      w_ncnt = w_ncnt + SEL_W'(w_nv[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_rd  <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_sc  <= '0;
    end else begin
      r_v   <= w_nv;
      r_rd  <= w_nrd;
      r_rem <= w_nrem;
      r_cnt <= w_ncnt;
      if (w_stall && r_sc != '1)
        r_sc <= r_sc + STALL_W'(1);
    end
  end

  assign stall        = w_stall;
  assign fwd_rs1_sel  = issue_valid ? w_sel1 : '0;
  assign fwd_rs2_sel  = issue_valid ? w_sel2 : '0;
  assign inflight_cnt = r_cnt;
  assign stall_cycles = r_sc;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed plus random check of hazard_scoreboard
// against an issue-history model of in-flight results.
module tb_hazard_scoreboard;
  localparam int AW = 5;
  localparam int DP = 3;
  localparam int LW = 2;
  localparam int SW = 4;
  localparam int SL = $clog2(DP+1);
  localparam int SMAX = (1 << SW) - 1;

  logic          clk;
  logic          rst_n;
  logic          iv;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          c1;
  logic          c2;
  logic [AW-1:0] rd;
  logic          we;
  logic [LW-1:0] lat;
  logic          fl;
  logic          stall;
  logic [SL-1:0] f1;
  logic [SL-1:0] f2;
  logic [SL-1:0] cnt;
  logic [SW-1:0] sc;

  hazard_scoreboard #(
    .REG_AW(AW), .DEPTH(DP), .LAT_W(LW), .STALL_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(iv), .issue_rs1(rs1), .issue_rs2(rs2),
    .issue_chk_rs1(c1), .issue_chk_rs2(c2),
    .issue_rd(rd), .issue_we(we), .issue_lat(lat),
    .flush(fl), .stall(stall),
    .fwd_rs1_sel(f1), .fwd_rs2_sel(f2),
    .inflight_cnt(cnt), .stall_cycles(sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int rd; int lat; int t; } ent_t;
  ent_t q[$];
  int   cyc;
  int   exp_sc;
  int   n_checks;
  int   n_fail;
  int   o_st, o_f1, o_f2, o_cnt, o_sc;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Youngest issued in-flight producer of rs; age 0 = issued last cycle.
  task automatic msrc(input int r, input bit ck,
                      output bit hit, output int age,
                      output int rem);
    hit = 0; age = 0; rem = 0;
    foreach (q[i]) begin
      int a;
      a = cyc - q[i].t - 1;
      if (ck && r != 0 && q[i].rd == r && a < DP &&
          (!hit || a < age)) begin
        hit = 1; age = a;
        rem = (q[i].lat > a) ? q[i].lat - a : 0;
      end
    end
  endtask

  task automatic step(input bit v, input int a1, input int a2,
                      input bit k1, input bit k2, input int d,
                      input bit w, input int l, input bit f);
    bit h1, h2, s1, s2, es;
    int g1, g2, r1, r2, e1, e2, ec;
    ent_t nq[$];
    iv = v; rs1 = AW'(a1); rs2 = AW'(a2);
    c1 = k1; c2 = k2; rd = AW'(d); we = w;
    lat = LW'(l); fl = f;
    #2;
    msrc(a1, k1, h1, g1, r1);
    msrc(a2, k2, h2, g2, r2);
`ifdef HAZARD_FWD_EN
    s1 = h1 && r1 != 0;
    s2 = h2 && r2 != 0;
    e1 = (v && h1 && r1 == 0) ? g1 + 1 : 0;
    e2 = (v && h2 && r2 == 0) ? g2 + 1 : 0;
`else
    s1 = h1; s2 = h2; e1 = 0; e2 = 0;
`endif
    es = v && !f && (s1 || s2);
    ec = q.size();
    chk("stall", int'(stall), int'(es));
    chk("fwd_rs1_sel", int'(f1), e1);
    chk("fwd_rs2_sel", int'(f2), e2);
    chk("inflight_cnt", int'(cnt), ec);
    chk("stall_cycles", int'(sc), exp_sc);
    o_st = int'(stall); o_f1 = int'(f1); o_f2 = int'(f2);
    o_cnt = int'(cnt); o_sc = int'(sc);
    if (es && exp_sc < SMAX) exp_sc++;
    if (f) q.delete();
    else if (v && !es && w && d != 0)
      q.push_back('{d, l, cyc});
    foreach (q[i])
      if (cyc - q[i].t < DP) nq.push_back(q[i]);
    q = nq;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_stall", int'(stall), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_sc", int'(sc), 0);
    q.delete();
    exp_sc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; exp_sc = 0;
    rst_n = 1'b0; iv = 0; rs1 = '0; rs2 = '0;
    c1 = 0; c2 = 0; rd = '0; we = 0; lat = '0; fl = 0;
    #7;
    chk("init_stall", int'(stall), 0);
    chk("init_f1", int'(f1), 0);
    chk("init_cnt", int'(cnt), 0);
    chk("init_sc", int'(sc), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD x5 then dependent ADD x6,x5
    step(1, 1, 2, 1, 1, 5, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    step(1, 5, 0, 1, 0, 6, 1, 0, 0);
    chk("t2_stall", o_st, 0);
    chk("t2_fwd1", o_f1, 1);
`else
    for (int i = 0; i < 3; i++) begin
      step(1, 5, 0, 1, 0, 6, 1, 0, 0);
      chk("t2_stall", o_st, 1);
    end
    step(1, 5, 0, 1, 0, 6, 1, 0, 0);
    chk("t2_free", o_st, 0);
`endif
    do_reset();

    // LW x7 (lat 1) then ADD x8,x7,x7
    step(1, 1, 0, 1, 0, 7, 1, 1, 0);
    step(1, 7, 7, 1, 1, 8, 1, 0, 0);
    chk("t3_stall", o_st, 1);
`ifdef HAZARD_FWD_EN
    step(1, 7, 7, 1, 1, 8, 1, 0, 0);
    chk("t3_stall2", o_st, 0);
    chk("t3_fwd1", o_f1, 2);
    chk("t3_fwd2", o_f2, 2);
    chk("t3_sc", o_sc, 1);
`else
    step(1, 7, 7, 1, 1, 8, 1, 0, 0);
    step(1, 7, 7, 1, 1, 8, 1, 0, 0);
    step(1, 7, 7, 1, 1, 8, 1, 0, 0);
    chk("t3_stall2", o_st, 0);
    chk("t3_sc", o_sc, 3);
`endif
    do_reset();

    // x0 never tracked; unchecked rs2 never matches
    step(1, 0, 0, 0, 0, 0, 1, 2, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("t4_stall", o_st, 0);
    chk("t4_fwd1", o_f1, 0);
    chk("t4_cnt", o_cnt, 0);
    step(1, 0, 0, 0, 0, 9, 1, 0, 0);
    step(1, 0, 9, 1, 0, 1, 0, 0, 0);
    chk("t4b_stall", o_st, 0);
    chk("t4b_fwd2", o_f2, 0);
    chk("t4b_cnt", o_cnt, 1);
    do_reset();

    // x3 in slots 0 and 2: youngest wins
    step(1, 0, 0, 0, 0, 3, 1, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 3, 1, 0, 0);
    step(1, 3, 0, 1, 0, 1, 0, 0, 0);
    chk("t5_cnt", o_cnt, 2);
`ifdef HAZARD_FWD_EN
    chk("t5_fwd1", o_f1, 1);
`else
    chk("t5_stall", o_st, 1);
`endif
    do_reset();

    // LW x4 then flush alongside a dependent issue
    step(1, 0, 0, 0, 0, 4, 1, 1, 0);
    step(1, 4, 0, 1, 0, 5, 1, 0, 1);
    chk("t6_stall", o_st, 0);
    step(1, 4, 0, 1, 0, 5, 1, 0, 0);
    chk("t6_cnt", o_cnt, 0);
    chk("t6_stall2", o_st, 0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3), $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
